div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage. It accepts DIV/DIVU operations issued by the decode/execute control path and holds the pipeline with a stall request while it iterates. It returns a 64-bit {remainder, quotient} result for the HI/LO write path. The divider is radix-2 restoring: one quotient bit per cycle, with sign fix-up for signed division.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 131 +++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the E-stage control path and div_unit.
// The control path drives the master side; the divider is the slave.
interface div_unit_if #(parameter int WIDTH = 32);
  logic                 start;
  logic                 signed_div;
  logic                 annul;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 stall_div;
  logic                 busy;

  modport master (
    output start, signed_div, annul, a, b,
    input  result, ready, stall_div, busy
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output result, ready, stall_div, busy
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// with sign fix-up for DIV, returning {remainder, quotient}.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 a_neg_q, a_neg_d;
  logic                 b_neg_q, b_neg_d;
  logic                 sgn_q, sgn_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       part_s;
  logic [WIDTH:0]       diff_s;
  logic                 qbit_s;
  logic [WIDTH-1:0]     rem_nx_s;
  logic [WIDTH-1:0]     quo_nx_s;
  logic [WIDTH-1:0]     quo_fix_s;
  logic [WIDTH-1:0]     rem_fix_s;

  // Datapath for one iteration: bit WIDTH of the difference is the borrow.
  always_comb begin
    part_s    = {rem_q, dvd_q[WIDTH-1]};
    diff_s    = part_s - {1'b0, dvs_q};
    qbit_s    = ~diff_s[WIDTH];
    rem_nx_s  = qbit_s ? diff_s[WIDTH-1:0] : part_s[WIDTH-1:0];
    quo_nx_s  = {dvd_q[WIDTH-2:0], qbit_s};
    quo_fix_s = (sgn_q & (a_neg_q ^ b_neg_q)) ? -quo_nx_s : quo_nx_s;
    rem_fix_s = (sgn_q & a_neg_q) ? -rem_nx_s : rem_nx_s;
  end

  // Next-state and register-update logic for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    sgn_d    = sgn_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start & ~bus.annul) begin
          if (bus.b == '0) begin
            result_d = {bus.a, {WIDTH{1'b1}}};
            state_d  = DONE;
          end else begin
            a_neg_d = bus.signed_div & bus.a[WIDTH-1];
            b_neg_d = bus.signed_div & bus.b[WIDTH-1];
            dvd_d   = (bus.signed_div & bus.a[WIDTH-1]) ? -bus.a : bus.a;
            dvs_d   = (bus.signed_div & bus.b[WIDTH-1]) ? -bus.b : bus.b;
            sgn_d   = bus.signed_div;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.annul) begin
          state_d = IDLE;
        end else begin
          dvd_d = quo_nx_s;
          rem_d = rem_nx_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = {rem_fix_s, quo_fix_s};
            state_d  = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      sgn_q    <= sgn_d;
      result_q <= result_d;
    end
  end

  // Stall drops in DONE so the instruction leaves E as the result is presented.
  assign bus.result    = result_q;
  assign bus.ready     = rst & (state_q == DONE);
  assign bus.busy      = rst & (state_q == BUSY);
  assign bus.stall_div = rst & (((state_q == IDLE) & bus.start & ~bus.annul) |
                                ((state_q == BUSY) & ~bus.annul));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results from a plain
// arithmetic model, and a monitor compares them whenever ready pulses.
module tb_div_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_res;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: truncating signed division from 64-bit arithmetic; b == 0 gives {a, ones}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb_l, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa   = longint'(signed'(a));
      sb_l = longint'(signed'(b));
      q    = sa / sb_l;
      r    = sa % sb_l;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Called just after a rising edge; returns just after the edge entering IDLE again.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s);
    int   lat;
    exp_t e;
    lat = (b == 32'd0) ? 1 : 33;
    bus.start      = 1'b1;
    bus.a          = a;
    bus.b          = b;
    bus.signed_div = s;
    e.res = ref_div(a, b, s);
    e.cyc = cyc + lat;
    sb.push_back(e);
    last_res = e.res;
    @(negedge clk);
    chk("stall_accept", {63'd0, bus.stall_div}, 64'd1);
    chk("busy_accept", {63'd0, bus.busy}, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("stall_run", {63'd0, bus.stall_div}, {63'd0, k < lat});
      chk("busy_run", {63'd0, bus.busy}, {63'd0, k < lat});
      if (k < lat) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready result=%h with nothing outstanding (cycle %0d)", bus.result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    last_res       = 64'd0;
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 64'd0);
    chk("reset_ready", {63'd0, bus.ready}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_stall", {63'd0, bus.stall_div}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    issue(32'd100, 32'd7, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'h0000_1234, 32'd0, 1'b0);
    issue(32'd1000, 32'd10, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(32'h8000_0000, 32'h8000_0001, 1'b0);

    // Annul in BUSY cycle 10: no ready, result kept, idle the next cycle.
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.signed_div = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", {63'd0, bus.stall_div}, 64'd0);
    chk("annul_busy", {63'd0, bus.busy}, 64'd1);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("annul_idle", {63'd0, bus.busy}, 64'd0);
    repeat (35) @(posedge clk);
    #1;
    chk("annul_keep", bus.result, last_res);

    // Reset in cycle 15 of a divide, with start held high to probe gating.
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    bus.start = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall_div}, 64'd0);
    chk("rst_ready", {63'd0, bus.ready}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd1;
      issue(ra, rb, rs);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
